axi_read_arbiter: RTL

- Shares a single AXI4-Lite read port between two requesters: m0 is the instruction fetch read channel (imem) and m1 is the data load read channel (dmem).
- Sits between the pipeline and a unified memory or interconnect port.
- Allows one outstanding read at a time, with round-robin or fixed-priority grant.
- The write channels of dmem bypass this block.

---
 rtl/axi_read_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI4-Lite read-channel arbiter (m0 = imem fetch, m1 = dmem load)
// sharing one slave read port with a single outstanding transaction.
module axi_read_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_axi_araddr,
    input  logic [2:0]  m0_axi_arprot,
    input  logic        m0_axi_arvalid,
    output logic        m0_axi_arready,
    output logic [31:0] m0_axi_rdata,
    output logic [1:0]  m0_axi_rresp,
    output logic        m0_axi_rvalid,
    input  logic        m0_axi_rready,

    input  logic [31:0] m1_axi_araddr,
    input  logic [2:0]  m1_axi_arprot,
    input  logic        m1_axi_arvalid,
    output logic        m1_axi_arready,
    output logic [31:0] m1_axi_rdata,
    output logic [1:0]  m1_axi_rresp,
    output logic        m1_axi_rvalid,
    input  logic        m1_axi_rready,

    output logic [31:0] s_axi_araddr,
    output logic [2:0]  s_axi_arprot,
    output logic        s_axi_arvalid,
    input  logic        s_axi_arready,
    input  logic [31:0] s_axi_rdata,
    input  logic [1:0]  s_axi_rresp,
    input  logic        s_axi_rvalid,
    output logic        s_axi_rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e state_q;
    logic   grant_q;
    logic   last_q;

    logic   any_req_s;
    logic   granted_rready_s;
    logic   r_hs_s;

    // Winner among current requesters; 'last' is the most recently served master.
    function automatic logic pick_f(input logic v0, input logic v1, input logic last);
        logic p;
        if (v0 && v1) begin
            if (ROUND_ROBIN) begin
                p = ~last;
            end else begin
                p = 1'b1;
            end
        end else if (v1) begin
            p = 1'b1;
        end else begin
            p = 1'b0;
        end
        return p;
    endfunction

    // Request summary and the R handshake of the granted master.
    always_comb begin
        any_req_s        = m0_axi_arvalid | m1_axi_arvalid;
        granted_rready_s = grant_q ? m1_axi_rready : m0_axi_rready;
        r_hs_s           = (state_q == ST_DATA) && s_axi_rvalid && granted_rready_s;
    end

    // Transaction FSM; grant moves only in IDLE or on the R handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_q <= pick_f(m0_axi_arvalid, m1_axi_arvalid, last_q);
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_axi_arready) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs_s) begin
                        last_q <= grant_q;
                        // Back-to-back re-arbitration uses the just-served master as 'last'.
                        if (any_req_s) begin
                            grant_q <= pick_f(m0_axi_arvalid, m1_axi_arvalid, grant_q);
                            state_q <= ST_ADDR;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output routing; everything is forced low while reset is held.
    always_comb begin
        s_axi_araddr   = 32'h0000_0000;
        s_axi_arprot   = 3'b000;
        s_axi_arvalid  = 1'b0;
        s_axi_rready   = 1'b0;
        m0_axi_arready = 1'b0;
        m1_axi_arready = 1'b0;
        m0_axi_rvalid  = 1'b0;
        m1_axi_rvalid  = 1'b0;
        m0_axi_rdata   = 32'h0000_0000;
        m1_axi_rdata   = 32'h0000_0000;
        m0_axi_rresp   = 2'b00;
        m1_axi_rresp   = 2'b00;
        if (!reset) begin
            s_axi_arvalid = 1'b0;
        end else begin
            s_axi_araddr = grant_q ? m1_axi_araddr : m0_axi_araddr;
            s_axi_arprot = grant_q ? m1_axi_arprot : m0_axi_arprot;
            m0_axi_rdata = s_axi_rdata;
            m1_axi_rdata = s_axi_rdata;
            m0_axi_rresp = s_axi_rresp;
            m1_axi_rresp = s_axi_rresp;
            case (state_q)
                ST_ADDR: begin
                    s_axi_arvalid  = 1'b1;
                    m0_axi_arready = ~grant_q & s_axi_arready;
                    m1_axi_arready =  grant_q & s_axi_arready;
                end
                ST_DATA: begin
                    s_axi_rready  = granted_rready_s;
                    m0_axi_rvalid = ~grant_q & s_axi_rvalid;
                    m1_axi_rvalid =  grant_q & s_axi_rvalid;
                end
                default: begin
                    s_axi_arvalid = 1'b0;
                end
            endcase
        end
    end

endmodule
